// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for a 3x3 binary convolution. A 16x16 image is buffered one row per beat.
// The 14x14 windows are then scanned one per cycle through a shared external MAC unit.
module conv_frame_sequencer #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int SUM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMG_W-1:0] in_row,
    output logic [8:0]       mac_window,
    input  logic [SUM_W-1:0] mac_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_data,
    output logic [3:0]       out_row,
    output logic [3:0]       out_col,
    output logic             out_last,
    output logic             busy
);

    localparam int AW = $clog2(IMG_W * IMG_H);
    localparam logic [3:0] LAST_BEAT = 4'(IMG_H - 1);
    localparam logic [3:0] LAST_ROW  = 4'(IMG_H - 3);
    localparam logic [3:0] LAST_COL  = 4'(IMG_W - 3);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [IMG_W*IMG_H-1:0] img_r;
    logic [3:0]             load_cnt_r;
    logic [3:0]             scan_row_r;
    logic [3:0]             scan_col_r;
    logic                   out_valid_r;
    logic [SUM_W-1:0]       out_data_r;
    logic [3:0]             out_row_r;
    logic [3:0]             out_col_r;
    logic                   out_last_r;
    logic [8:0]             win_s;
    logic                   load_fire_s;
    logic                   capture_s;
    logic                   last_pos_s;

    // Window bit i*3+j is pixel (r+i, c+j), so bit0 = (r,c) and bit8 = (r+2,c+2).
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
        for (genvar gj = 0; gj < 3; gj++) begin : g_win_col
            assign win_s[gi*3+gj] =
                img_r[AW'((int'(scan_row_r) + gi) * IMG_W + int'(scan_col_r) + gj)];
        end
    end

    assign load_fire_s = (state_r == ST_LOAD) && in_valid;
    assign last_pos_s  = (scan_row_r == LAST_ROW) && (scan_col_r == LAST_COL);
    assign capture_s   = (state_r == ST_SCAN) && (!out_valid_r || out_ready);

    // Next-state selection for the load / scan / drain sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (load_fire_s && (load_cnt_r == LAST_BEAT)) begin
                    state_next_s = ST_SCAN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_SCAN: begin
                if (capture_s && last_pos_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_LOAD;
        endcase
    end

    // Image buffer; contents after reset are irrelevant because a full frame is always reloaded.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            img_r[AW'(int'(load_cnt_r) * IMG_W) +: IMG_W] <= in_row;
        end
    end

    // State, counters and the registered result stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOAD;
            load_cnt_r  <= 4'd0;
            scan_row_r  <= 4'd0;
            scan_col_r  <= 4'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_row_r   <= 4'd0;
            out_col_r   <= 4'd0;
            out_last_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (load_fire_s) begin
                load_cnt_r <= (load_cnt_r == LAST_BEAT) ? 4'd0 : load_cnt_r + 4'd1;
            end
            if (capture_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= mac_sum;
                out_row_r   <= scan_row_r;
                out_col_r   <= scan_col_r;
                out_last_r  <= last_pos_s;
                if (scan_col_r == LAST_COL) begin
                    scan_col_r <= 4'd0;
                    scan_row_r <= (scan_row_r == LAST_ROW) ? 4'd0 : scan_row_r + 4'd1;
                end else begin
                    scan_col_r <= scan_col_r + 4'd1;
                end
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready   = (state_r == ST_LOAD);
    assign busy       = (state_r == ST_SCAN) || (state_r == ST_DRAIN);
    assign mac_window = win_s;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_row    = out_row_r;
    assign out_col    = out_col_r;
    assign out_last   = out_last_r;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer: random and directed frames against a
// window/popcount reference model, with backpressure, garbage input and mid-frame resets.
module tb_conv_frame_sequencer;

    localparam int NRES = 196;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] c;
        logic [3:0] d;
        logic       last;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_row;
    logic [8:0]  mac_window;
    logic [3:0]  mac_sum;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [3:0]  out_row;
    logic [3:0]  out_col;
    logic        out_last;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int nz_cnt = 0;
    int cap_cnt = 0;
    int ready_mode = 0;
    int tog = 0;
    res_t exp_q[$];
    logic [255:0] img_m = '0;
    logic [15:0] rows [16];

    logic       pv_valid = 1'b0;
    logic       pv_ready = 1'b0;
    logic [3:0] pv_data, pv_row, pv_col;
    logic       pv_last;

    conv_frame_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .mac_window(mac_window), .mac_sum(mac_sum), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // External MAC unit: popcount of the window.
    assign mac_sum = 4'($countones(mac_window));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_win(input logic [255:0] img, input int r, input int c);
        logic [8:0] w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i*3+j] = img[(r+i)*16 + c + j];
        return w;
    endfunction

    // Monitor: window sequence, result scoreboard, output stability; drives out_ready.
    always @(negedge clk) begin
        if (rst) begin
            cap_cnt  = 0;
            pv_valid = 1'b0;
        end else begin
            check("ready_vs_busy", 32'(in_ready), 32'(!busy));
            if (pv_valid && !pv_ready) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(pv_data));
                check("stall_row", 32'(out_row), 32'(pv_row));
                check("stall_col", 32'(out_col), 32'(pv_col));
                check("stall_last", 32'(out_last), 32'(pv_last));
            end
            if (!busy) cap_cnt = 0;
            if (busy && cap_cnt < NRES)
                check("window", 32'(mac_window), 32'(model_win(img_m, cap_cnt / 14, cap_cnt % 14)));
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ((tog % 4) == 0) || ((tog % 4) == 3);
                    tog++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (busy && cap_cnt < NRES && (!out_valid || out_ready)) cap_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_result", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_row", 32'(out_row), 32'(e.r));
                    check("out_col", 32'(out_col), 32'(e.c));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
                acc_cnt++;
                if (out_data != 4'd0) nz_cnt++;
            end
            pv_valid = out_valid;
            pv_ready = out_ready;
            pv_data  = out_data;
            pv_row   = out_row;
            pv_col   = out_col;
            pv_last  = out_last;
        end
    end

    task automatic send_frame(input int nbeats);
        int n;
        exp_q.delete();
        for (int k = 0; k < 16; k++) img_m[k*16 +: 16] = rows[k];
        if (nbeats == 16) begin
            for (int r = 0; r < 14; r++)
                for (int c = 0; c < 14; c++) begin
                    res_t e;
                    e.r = 4'(r);
                    e.c = 4'(c);
                    e.d = 4'($countones(model_win(img_m, r, c)));
                    e.last = (r == 13) && (c == 13);
                    exp_q.push_back(e);
                end
        end
        acc_cnt = 0;
        nz_cnt  = 0;
        for (int k = 0; k < nbeats; k++) begin
            n = 0;
            while (!in_ready && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            check("load_timeout", 32'(n < 1000), 32'd1);
            in_valid = 1'b1;
            in_row   = rows[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Waits for the frame to drain, optionally driving garbage beats while busy.
    task automatic wait_done(input bit garbage, output int cycles);
        int n = 0;
        while (!in_ready && n < 3000) begin
            in_valid = garbage;
            in_row   = 16'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        cycles   = n;
        check("frame_timeout", 32'(n < 3000), 32'd1);
        check("accepted_count", 32'(acc_cnt), NRES);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset_check();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_rowcol", 32'({out_row, out_col}), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 16; k++) rows[k] = 16'($urandom);
    endtask

    task automatic fill_ones();
        for (int k = 0; k < 16; k++) rows[k] = 16'hFFFF;
    endtask

    initial begin
        int cyc;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_row = 16'h0000;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset_check();

        // All ones with latency checks.
        ready_mode = 0;
        fill_ones();
        send_frame(16);
        check("lat_busy_T1", 32'(busy), 32'd1);
        check("lat_noval_T1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid_T2", 32'(out_valid), 32'd1);
        wait_done(1'b0, cyc);
        check("lat_in_ready", 32'(cyc + 1), 32'd197);
        check("ones_nonzero", 32'(nz_cnt), NRES);

        // Checkerboard.
        for (int k = 0; k < 16; k++) rows[k] = (k % 2 == 0) ? 16'h5555 : 16'hAAAA;
        send_frame(16);
        check("cb_window00", 32'(mac_window), 32'h155);
        wait_done(1'b0, cyc);

        // Single pixel at (5,7).
        for (int k = 0; k < 16; k++) rows[k] = 16'h0000;
        rows[5] = 16'h0080;
        send_frame(16);
        wait_done(1'b0, cyc);
        check("pixel_nonzero", 32'(nz_cnt), 32'd9);

        // Backpressure 1,0,0,1.
        ready_mode = 1;
        tog = 0;
        fill_random();
        send_frame(16);
        wait_done(1'b0, cyc);

        // Random backpressure plus garbage rows during scan, then a clean frame.
        ready_mode = 2;
        fill_random();
        send_frame(16);
        wait_done(1'b1, cyc);
        fill_random();
        send_frame(16);
        wait_done(1'b0, cyc);

        // Reset mid-load, then a fresh all-ones frame.
        ready_mode = 0;
        fill_random();
        send_frame(8);
        do_reset_check();
        fill_ones();
        send_frame(16);
        wait_done(1'b0, cyc);
        check("ones_after_load_rst", 32'(nz_cnt), NRES);

        // Reset mid-scan after 50 results.
        fill_random();
        send_frame(16);
        n = 0;
        while (acc_cnt < 50 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("midscan_timeout", 32'(n < 1000), 32'd1);
        do_reset_check();
        ready_mode = 2;
        fill_ones();
        send_frame(16);
        wait_done(1'b0, cyc);
        check("ones_after_scan_rst", 32'(nz_cnt), NRES);

        // A few more random frames under random backpressure.
        for (int f = 0; f < 3; f++) begin
            fill_random();
            send_frame(16);
            wait_done(f == 1, cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Time-multiplexed controller for the binary 3x3 convolution datapath.
- Accepts a 16x16 binary image one 16-bit row per handshake and buffers it internally.
- Scans all 14x14 window positions in raster order, one per cycle, driving a single external combinational MAC_UNIT (9-bit window in, 4-bit sum out).
- Streams each 4-bit result out with valid/ready and row/column tags. Replaces the fully parallel 196-MAC array where area matters.

Parameters:
- IMG_W, 16, image width in pixels (row beat width).
- IMG_H, 16, image height in rows (beats per frame).
- SUM_W, 4, MAC result width.
- Output grid is fixed at (IMG_H-2) x (IMG_W-2) = 14x14, 196 results per frame.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  row beat valid.
- in_ready  out  1  sequencer accepts a row beat.
- in_row  in  IMG_W  one image row; bit c = column c.
- mac_window  out  9  window to external MAC_UNIT.a.
- mac_sum  in  SUM_W  combinational result from MAC_UNIT.sum.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  SUM_W  convolution result.
- out_row  out  4  output row index 0..13.
- out_col  out  4  output column index 0..13.
- out_last  out  1  high with the result for (13,13).
- busy  out  1  high in SCAN or DRAIN.

Behaviour:
- Image buffer: 256 bits. Pixel (r,c) = bit r*16+c. Beat k (0..15) writes bits k*16 +: 16.
- Window for position (r,c), MSB..LSB: (r+2,c+2),(r+2,c+1),(r+2,c),(r+1,c+2),(r+1,c+1),(r+1,c),(r,c+2),(r,c+1),(r,c).
  - Equivalently, bit0 = (r,c) and bit8 = (r+2,c+2).
  - mac_window is combinational from the buffer and the scan counters.
- States:
  - LOAD (reset state):
    - in_ready=1.
    - Each in_valid&in_ready writes buffer row load_cnt, then load_cnt++.
    - On the accepted beat with load_cnt=15: load_cnt<=0, go to SCAN.
  - SCAN:
    - in_ready=0.
    - scan (r,c) starts at (0,0); mac_window reflects (r,c).
    - Capture condition: output register empty or being accepted (out_valid=0 or out_ready=1). On capture:
      - out_data<=mac_sum, out_row<=r, out_col<=c, out_last<=(r==13&&c==13), out_valid<=1.
      - Advance c; at c=13 wrap c<=0 and r++.
    - Capture of (13,13): go to DRAIN.
    - Capture not possible: counters hold, mac_window stable.
  - DRAIN:
    - Holds until the (13,13) result is accepted. Then out_valid<=0, go to LOAD; in_ready=1 the following cycle.
  - Accept without a new capture (SCAN stalled cannot occur; DRAIN or idle): out_valid<=0.
- Output stability: while out_valid=1 and out_ready=0, out_data/out_row/out_col/out_last hold unchanged.
- Latency:
  - Last input beat accepted in cycle T: SCAN in T+1, first out_valid in T+2.
  - With out_ready held 1: 196 consecutive out_valid cycles, then in_ready=1 at T+198.
- in_valid while in_ready=0 is ignored; no buffer write.
- busy=1 in SCAN and DRAIN.
- rst=1 at any point, including mid-load or mid-scan:
  - Next cycle: state LOAD, load_cnt=0, r=c=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, in_ready=1, busy=0.
  - Buffer contents are don't-care; a partial frame is discarded.
- Widths: mac_sum is taken as-is, no saturation; max 9 fits in 4 bits.

Test Plan:
- All-ones image, 16 beats of 16'hFFFF, out_ready=1, MAC=popcount:
  - 196 results, all 9, raster order (0,0)..(13,13).
  - out_last only on the final result.
  - First out_valid 2 cycles after the last beat.
- Checkerboard, pixel=1 when (r+c) even, rows alternating 16'h5555/16'hAAAA:
  - out_data=5 where (r+c) even, 4 where odd.
  - mac_window at (0,0)=9'b101010101.
- Single pixel (5,7)=1, all else 0:
  - Nonzero (value 1) only at r in 3..5, c in 5..7; 9 results, all others 0.
- Backpressure, out_ready toggling 1,0,0,1 repeatedly:
  - No result lost or duplicated; exactly 196 accepted.
  - Outputs stable during stalls; in_ready stays 0 until (13,13) is accepted.
- in_valid=1 with garbage rows during SCAN:
  - Results unchanged versus the clean run; next frame loads correctly afterwards.
- rst asserted mid-load (beat 8) and mid-scan (result 50):
  - Next cycle: out_valid=0, in_ready=1, busy=0.
  - A fresh all-ones frame then yields 196 results of 9.
